// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: scan chain test sequencer.
// Shifts a pattern into the chain MSB first, runs CAPTURE_CYCLES functional
// clocks, shifts the response out, and presents it as a parallel word with a
// one-cycle done pulse. Every output is taken straight from a flop.
// Optional feature: define SCAN_SEQ_CMP_EN to latch expected_in at start and
// drive pass with the response compare. Without it, pass is tied low and
// expected_in is ignored.
// The response shifts through an internal register that is cleared at start.
// The response port loads only on DONE entry, so an aborted run leaves the
// previous response and pass visible.
module scan_seq_ctrl #(
  parameter int CHAIN_LEN      = 8,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected_in,
  input  logic                 chain_so,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 pass
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LEN_LOAD = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LOAD = CNT_W'(CAPTURE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] resp_sh_q, resp_sh_d;
  logic [CHAIN_LEN-1:0] response_q, response_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

`ifdef SCAN_SEQ_CMP_EN
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic                 pass_q, pass_d;
`else
  // Intentionally ignored input when the compare feature is compiled out.
  logic                 expected_unused;
  assign expected_unused = ^expected_in;
`endif

  // Next-state, shared down-counter, data shifting and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    resp_sh_d  = resp_sh_q;
    response_d = response_q;
`ifdef SCAN_SEQ_CMP_EN
    exp_d      = exp_q;
    pass_d     = pass_q;
`endif

    case (state_q)
      IDLE: begin
        // abort together with start keeps the sequencer idle.
        if (start && !abort) begin
          state_d   = SHIFT_IN;
          cnt_d     = LEN_LOAD;
          pat_d     = pattern_in;
          resp_sh_d = '0;
`ifdef SCAN_SEQ_CMP_EN
          exp_d     = expected_in;
`endif
        end
      end
      SHIFT_IN: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
          cnt_d   = CAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
          pat_d = pat_q << 1;
        end
      end
      CAPTURE: begin
        if (cnt_q == '0) begin
          state_d = SHIFT_OUT;
          cnt_d   = LEN_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHIFT_OUT: begin
        resp_sh_d = {resp_sh_q[CHAIN_LEN-2:0], chain_so};
        if (cnt_q == '0) begin
          state_d    = DONE;
          cnt_d      = '0;
          response_d = resp_sh_d;
`ifdef SCAN_SEQ_CMP_EN
          pass_d     = (resp_sh_d == exp_q);
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides the normal transition and freezes the result registers.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      cnt_d      = '0;
      resp_sh_d  = resp_sh_q;
      response_d = response_q;
`ifdef SCAN_SEQ_CMP_EN
      pass_d     = pass_q;
`endif
    end

    // Outputs are decoded from the next state so they register with it.
    scan_en_d = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
    scan_in_d = (state_d == SHIFT_IN) ? pat_d[CHAIN_LEN-1] : 1'b0;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  // Control state and registered outputs, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      response_q <= '0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      response_q <= response_d;
      scan_en_q  <= scan_en_d;
      scan_in_q  <= scan_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Pattern and response shift registers; always reloaded at start, so no reset.
  always_ff @(posedge clk) begin
    pat_q     <= pat_d;
    resp_sh_q <= resp_sh_d;
  end

`ifdef SCAN_SEQ_CMP_EN
  // Compare result is visible outside, so it resets; the expected word does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  // Expected word latched at start.
  always_ff @(posedge clk) begin
    exp_q <= exp_d;
  end

  assign pass = pass_q;
`else
  assign pass = 1'b0;
`endif

  assign scan_en  = scan_en_q;
  assign scan_in  = scan_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = response_q;

endmodule
